pipe_control: RTL

Successor to the single-cycle decoder, for the 5-stage pipelined MIPS core. It decodes the ID-stage instruction into a control vector and carries that vector through the ID/EX, EX/MEM and MEM/WB control registers. It also owns the load-use interlock, the branch/jump flush and the syscall-exit halt state machine. It sits between the IF/ID register and the datapath stage registers, which are owned elsewhere.

---
 rtl/pipe_ctrl_pkg.sv | 62 ++++++
 rtl/pipe_control_instr_decode.sv | 107 ++++++++++
 rtl/pipe_control.sv | 108 ++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode/funct constants, ALU modes, pipeline control-vector types and
// FSM encoding for the pipelined MIPS control unit.
package pipe_ctrl_pkg;

   localparam int REG_W = 5;
   localparam int ALU_W = 4;

   localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02,
                          OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05,
                          OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A,
                          OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_LUI   = 6'h0F,
                          OP_LW      = 6'h23, OP_SH     = 6'h29, OP_SW    = 6'h2B;

   localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA = 6'h03, F_JR  = 6'h08,
                          F_SYSC = 6'h0C, F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22,
                          F_AND  = 6'h24, F_OR   = 6'h25, F_NOR = 6'h27, F_SLT = 6'h2A,
                          F_SLTU = 6'h2B;

   localparam logic [4:0] RT_BGEZ = 5'd1;

   // {bgez,bne,beq}
   localparam logic [2:0] BR_BEQ = 3'b001, BR_BNE = 3'b010, BR_BGEZ = 3'b100;

   typedef enum logic [ALU_W-1:0] {
      ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
      ALU_NOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
      ALU_SRL = 4'd8, ALU_SRA = 4'd9, ALU_LUI = 4'd10
   } alu_mode_e;

   typedef struct packed {
      alu_mode_e        alumode;
      logic             alusrc_im;
      logic [2:0]       branch;
      logic             mem_write;
      logic             mem_half;
      logic             mem_read;
      logic             regwrite;
      logic [REG_W-1:0] dst;
      logic             illegal;
   } ctrl_vec_t;

   typedef struct packed {
      logic             mem_write;
      logic             mem_half;
      logic             mem_read;
      logic             regwrite;
      logic [REG_W-1:0] dst;
   } mem_ctrl_t;

   typedef struct packed {
      logic             regwrite;
      logic [REG_W-1:0] dst;
   } wb_ctrl_t;

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} pipe_state_e;

   function automatic mem_ctrl_t to_mem(input ctrl_vec_t c);
      to_mem = '{mem_write: c.mem_write, mem_half: c.mem_half, mem_read: c.mem_read,
                 regwrite: c.regwrite, dst: c.dst};
   endfunction

endpackage

// File: rtl/pipe_control_instr_decode.sv
// Combinational ID-stage decoder: instruction word to control vector, plus the
// operand-read and jump flags the hazard logic needs.
module instr_decode
   import pipe_ctrl_pkg::*;
(
   input  logic [31:0] in_is,
   output ctrl_vec_t   out_ctrl,
   output logic        out_reads_rs,
   output logic        out_reads_rt,
   output logic        out_jump
);

   logic [5:0]       op, fn;
   logic [REG_W-1:0] rt, rd;
   logic             legal;
   logic             unused_bits;

   assign op = in_is[31:26];
   assign rt = in_is[20:16];
   assign rd = in_is[15:11];
   assign fn = in_is[5:0];
   assign unused_bits = ^{in_is[25:21], in_is[10:6]};

   always_comb begin
      out_ctrl     = '0;
      out_reads_rs = 1'b1;
      out_reads_rt = 1'b0;
      out_jump     = 1'b0;
      legal        = 1'b1;
      out_ctrl.dst = (op == OP_SPECIAL) ? rd : rt;
      case (op)
         OP_SPECIAL: begin
            out_reads_rt      = 1'b1;
            out_ctrl.regwrite = 1'b1;
            case (fn)
               F_ADD, F_ADDU: out_ctrl.alumode = ALU_ADD;
               F_SUB:         out_ctrl.alumode = ALU_SUB;
               F_AND:         out_ctrl.alumode = ALU_AND;
               F_OR:          out_ctrl.alumode = ALU_OR;
               F_NOR:         out_ctrl.alumode = ALU_NOR;
               F_SLT:         out_ctrl.alumode = ALU_SLT;
               F_SLTU:        out_ctrl.alumode = ALU_SLTU;
               F_SLL:         out_ctrl.alumode = ALU_SLL;
               F_SRL:         out_ctrl.alumode = ALU_SRL;
               F_SRA:         out_ctrl.alumode = ALU_SRA;
               F_JR: begin
                  out_jump          = 1'b1;
                  out_ctrl.regwrite = 1'b0;
               end
               F_SYSC:        out_ctrl.regwrite = 1'b0;
               default:       legal = 1'b0;
            endcase
         end
         OP_REGIMM: begin
            if (rt == RT_BGEZ) out_ctrl.branch = BR_BGEZ;
            else               legal = 1'b0;
         end
         OP_J: begin
            out_jump     = 1'b1;
            out_ctrl.dst = '0;
         end
         OP_JAL: begin
            out_jump          = 1'b1;
            out_ctrl.regwrite = 1'b1;
            out_ctrl.dst      = REG_W'(31);
         end
         OP_BEQ, OP_BNE: begin
            out_reads_rt     = 1'b1;
            out_ctrl.alumode = ALU_SUB;
            out_ctrl.branch  = (op == OP_BEQ) ? BR_BEQ : BR_BNE;
         end
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
            out_ctrl.alusrc_im = 1'b1;
            out_ctrl.regwrite  = 1'b1;
            case (op)
               OP_SLTI: out_ctrl.alumode = ALU_SLT;
               OP_ANDI: out_ctrl.alumode = ALU_AND;
               OP_ORI:  out_ctrl.alumode = ALU_OR;
               OP_LUI:  out_ctrl.alumode = ALU_LUI;
               default: out_ctrl.alumode = ALU_ADD;
            endcase
         end
         OP_LW: begin
            out_ctrl.alusrc_im = 1'b1;
            out_ctrl.mem_read  = 1'b1;
            out_ctrl.regwrite  = 1'b1;
         end
         OP_SW, OP_SH: begin
            out_reads_rt       = 1'b1;
            out_ctrl.alusrc_im = 1'b1;
            out_ctrl.mem_write = 1'b1;
            out_ctrl.mem_half  = (op == OP_SH);
         end
         default: legal = 1'b0;
      endcase
      if (out_ctrl.dst == '0) out_ctrl.regwrite = 1'b0;
      // Unknown encodings travel as a NOP that only carries the illegal marker.
      if (!legal) begin
         out_ctrl         = '0;
         out_ctrl.illegal = 1'b1;
         out_reads_rs     = 1'b0;
         out_reads_rt     = 1'b0;
         out_jump         = 1'b0;
      end
   end

endmodule

// File: rtl/pipe_control.sv
// Pipeline control for the 5-stage MIPS core: decode, ID/EX..MEM/WB control
// registers, load-use interlock, branch/jump flush and syscall-exit halt FSM.
module pipe_control
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_ADDR_W         = 5,
   parameter int ALU_MODE_W         = 4,
   parameter int LOAD_USE_INTERLOCK = 1,
   parameter int HALT_DRAIN         = 2
) (
   input  logic                  in_clk,
   input  logic                  in_rst_n,
   input  logic [31:0]           in_is,
   input  logic                  in_valid,
   input  logic                  in_branch_taken,
   input  logic                  in_syscall_exit,
   input  logic                  in_resume,
   output logic                  out_stall,
   output logic                  out_flush,
   output logic [ALU_MODE_W-1:0] out_ex_alumode,
   output logic                  out_ex_alusrc_im,
   output logic [2:0]            out_ex_branch,
   output logic                  out_mem_write,
   output logic                  out_mem_half,
   output logic                  out_mem_read,
   output logic                  out_wb_regwrite,
   output logic [REG_ADDR_W-1:0] out_wb_dst,
   output logic                  out_illegal,
   output logic                  out_halted
);

   localparam logic [1:0] DRAIN_INIT = 2'(HALT_DRAIN - 1);

   ctrl_vec_t        id_ctrl, id_ex;
   mem_ctrl_t        ex_mem;
   wb_ctrl_t         mem_wb;
   pipe_state_e      state;
   logic [1:0]       drain_cnt;
   logic             reads_rs, reads_rt, jump;
   logic             load_use, fsm_stall, bubble;
   logic [REG_W-1:0] rs, rt;

   instr_decode u_dec (
      .in_is        (in_is),
      .out_ctrl     (id_ctrl),
      .out_reads_rs (reads_rs),
      .out_reads_rt (reads_rt),
      .out_jump     (jump)
   );

   assign rs = in_is[25:21];
   assign rt = in_is[20:16];

   assign load_use = (LOAD_USE_INTERLOCK != 0) && in_valid && id_ex.mem_read &&
                     (id_ex.dst != '0) &&
                     ((reads_rs && rs == id_ex.dst) || (reads_rt && rt == id_ex.dst));
   assign fsm_stall = (state != ST_RUN);

   // A taken branch squashes the ID instruction, so a load-use stall on it is moot.
   assign out_stall = fsm_stall | (load_use & ~in_branch_taken);
   // Jumps kill only the IF/ID successor; a held jump must not flush itself away.
   assign out_flush = in_branch_taken | (in_valid & jump & ~out_stall);
   assign bubble    = ~in_valid | out_stall | in_branch_taken;

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         id_ex  <= '0;
         ex_mem <= '0;
         mem_wb <= '0;
      end else begin
         id_ex  <= bubble ? ctrl_vec_t'('0) : id_ctrl;
         ex_mem <= to_mem(id_ex);
         mem_wb <= '{regwrite: ex_mem.regwrite, dst: ex_mem.dst};
      end
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         state     <= ST_RUN;
         drain_cnt <= '0;
      end else begin
         case (state)
            ST_RUN: if (in_syscall_exit) begin
               state     <= ST_DRAIN;
               drain_cnt <= DRAIN_INIT;
            end
            ST_DRAIN: begin
               if (drain_cnt == '0) state <= ST_HALTED;
               else                 drain_cnt <= drain_cnt - 2'd1;
            end
            ST_HALTED: if (in_resume) state <= ST_RUN;
            default: state <= ST_RUN;
         endcase
      end
   end

   assign out_ex_alumode   = ALU_MODE_W'(id_ex.alumode);
   assign out_ex_alusrc_im = id_ex.alusrc_im;
   assign out_ex_branch    = id_ex.branch;
   assign out_illegal      = id_ex.illegal;
   assign out_mem_write    = ex_mem.mem_write;
   assign out_mem_half     = ex_mem.mem_half;
   assign out_mem_read     = ex_mem.mem_read;
   assign out_wb_regwrite  = mem_wb.regwrite;
   assign out_wb_dst       = REG_ADDR_W'(mem_wb.dst);
   assign out_halted       = (state == ST_HALTED);

endmodule
